nand_latch_sequencer: RTL and testbench
=======================================

// Module: nand_latch_sequencer
// PURPOSE
//  Drives one command latch unit and one address latch unit to issue a full ONFI
//  command cycle: CMD0, 0-5 address bytes, then an optional CMD1.
//  Sits between the operation-level controller and the two latch units.
//  Owns the activate strobes and the byte data fed to each unit.
//  Sequences on the units' busy handshakes and guards each step with a timeout.
// PARAMETERS
//  MAX_ADDR  5     maximum address cycles per request (addr_cnt clamped to this)
//  TIMEOUT   1023  cycles a latch unit may stay busy per step before abort
//  TO_W      10    width of the timeout counter (2**TO_W > TIMEOUT)
// PORTS
//  clk           in   1   system clock, all logic on rising edge
//  reset         in   1   asynchronous, active-high reset
//  start         in   1   request strobe; accepted only when ready=1
//  cmd0          in   8   first command byte
//  addr          in   40  address bytes; byte0 = addr[7:0] is sent first
//  addr_cnt      in   3   number of address cycles, 0..MAX_ADDR
//  cmd1_en       in   1   1 = send cmd1 after the address cycles
//  cmd1          in   8   second command byte (e.g. 0x30 confirm)
//  ready         out  1   idle, both units initialized and not busy
//  done          out  1   one-cycle pulse on successful completion
//  error         out  1   one-cycle pulse on timeout abort
//  cmd_activate  out  1   activate to the command latch unit
//  cmd_data      out  16  data_in to the command latch unit
//  cmd_busy      in   1   busy from the command latch unit
//  cmd_init      in   1   initialized from the command latch unit
//  addr_activate out  1   activate to the address latch unit
//  addr_data     out  16  data_in to the address latch unit
//  addr_busy     in   1   busy from the address latch unit
//  addr_init     in   1   initialized from the address latch unit
// BEHAVIOUR
//  Reset: state=IDLE; done, error, cmd_activate, addr_activate = 0.
//   cmd_data and addr_data = 16'h0000. All request registers cleared.
//   Reset mid-operation aborts immediately; no done or error pulse follows.
//  ready = (state==IDLE) & cmd_init & addr_init & ~cmd_busy & ~addr_busy.
//  Accept: start & ready registers cmd0, addr, min(addr_cnt,MAX_ADDR), cmd1_en, cmd1.
//   start while ready=0 is ignored (not queued).
//  Data outputs: cmd_data = {8'h00, current cmd byte}.
//   addr_data = {8'h00, addr byte[idx]}.
//   Both are held stable from the REQ cycle until the step's WAIT exits.
//  States:
//   IDLE -> C0_REQ on accept.
//   C0_REQ:  cmd_activate=1 for exactly 1 cycle -> C0_ARM.
//   C0_ARM:  1 cycle, busy ignored (the unit raises busy the cycle after activate) -> C0_WAIT.
//   C0_WAIT: when cmd_busy=0:
//            -> A_REQ if addr_cnt!=0
//            -> else C1_REQ if cmd1_en
//            -> else DONE.
//   A_REQ:   addr_activate=1 for 1 cycle, byte idx -> A_ARM -> A_WAIT.
//   A_WAIT:  on addr_busy=0, idx+1:
//            -> A_REQ while idx+1 < addr_cnt
//            -> else C1_REQ if cmd1_en
//            -> else DONE.
//   C1_REQ -> C1_ARM -> C1_WAIT: same handshake as CMD0 -> DONE.
//   DONE: done=1 for 1 cycle -> IDLE.
//   ABORT: error=1 for 1 cycle; outputs zeroed -> IDLE.
//  Activates are never asserted while the target unit's busy=1; never both at once.
//  Timeout: counter clears on each REQ, increments in ARM and WAIT.
//   Reaching TIMEOUT while still in WAIT -> ABORT (saturates, no wrap).
//  addr_cnt > MAX_ADDR is clamped; idx is 3 bits, max value MAX_ADDR-1.
//  Either *_init dropping to 0 outside IDLE -> ABORT on the next cycle.
//  Minimum total latency = sum over steps of (REQ + ARM + unit busy cycles) + 1 DONE cycle.
// TESTING
//  1. Reset, then init inputs=1 -> ready=1 and all outputs 0.
//     start with cmd0=0xFF, addr_cnt=0, cmd1_en=0 -> one cmd_activate, cmd_data=0x00FF, done once.
//  2. Read sequence: cmd0=0x00, addr=0x0504030201, cnt=5, cmd1=0x30.
//     -> addr_data 0x01,02,03,04,05 in order, then cmd_data=0x0030, done pulse.
//  3. Behavioural latch model holds busy forever after the 2nd address byte
//     -> error pulse TIMEOUT cycles later, state IDLE, no done.
//  4. start pulsed while busy, and again while cmd_init=0 -> ignored, no activate.
//  5. Assert reset during A_WAIT -> outputs 0 at once, no pulses after.
//     Next request runs normally.
//  6. addr_cnt=7 -> exactly 5 address activates.
//     Check no activate overlaps a busy=1 on its own unit.

Source files
------------

// File: rtl/nand_latch_sequencer.sv
// nand_latch_sequencer
// Issues one ONFI command cycle (CMD0, up to MAX_ADDR address bytes, optional
// CMD1) by pulsing the activate strobes of a command latch unit and an address
// latch unit. Each step waits for the unit's busy handshake and gives up after
// TIMEOUT cycles. Dropping either unit's init while active also aborts.
module nand_latch_sequencer #(
    parameter int MAX_ADDR = 5,
    parameter int TIMEOUT  = 1023,
    parameter int TO_W     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  cmd0,
    input  logic [39:0] addr,
    input  logic [2:0]  addr_cnt,
    input  logic        cmd1_en,
    input  logic [7:0]  cmd1,
    output logic        ready,
    output logic        done,
    output logic        error,
    output logic        cmd_activate,
    output logic [15:0] cmd_data,
    input  logic        cmd_busy,
    input  logic        cmd_init,
    output logic        addr_activate,
    output logic [15:0] addr_data,
    input  logic        addr_busy,
    input  logic        addr_init
);

    typedef enum logic [3:0] {
        IDLE, C0_REQ, C0_ARM, C0_WAIT,
        A_REQ, A_ARM, A_WAIT,
        C1_REQ, C1_ARM, C1_WAIT,
        DONE, ABORT
    } state_t;

    localparam logic [2:0]      L_MAX_ADDR = 3'(MAX_ADDR);
    localparam logic [TO_W-1:0] L_TIMEOUT  = TO_W'(TIMEOUT);

    state_t          r_state;
    logic [7:0]      r_cmd0;
    logic [39:0]     r_addr;
    logic [2:0]      r_addrCnt;
    logic            r_cmd1En;
    logic [7:0]      r_cmd1;
    logic [2:0]      r_idx;
    logic [TO_W-1:0] r_toCnt;
    logic            r_done;
    logic            r_error;
    logic            r_cmdAct;
    logic            r_addrAct;
    logic [15:0]     r_cmdData;
    logic [15:0]     r_addrData;

    logic       w_ready;
    logic       w_accept;
    logic [2:0] w_cntClamped;
    logic       w_initLost;
    logic       w_ownBusy;
    logic       w_tgtBusy;
    logic       w_goAddr;
    logic       w_goCmd1;
    logic [2:0] w_nextIdx;
    logic       w_stepClear;
    logic       w_timedOut;

    // Selects address byte i, byte 0 being the least significant one
    function automatic logic [7:0] addrByte(input logic [39:0] a, input logic [2:0] i);
        logic [39:0] s;
        s = a >> {i, 3'b000};
        return s[7:0];
    endfunction

    assign w_ready      = (r_state == IDLE) & cmd_init & addr_init & ~cmd_busy & ~addr_busy;
    assign w_accept     = start & w_ready;
    assign w_cntClamped = (addr_cnt > L_MAX_ADDR) ? L_MAX_ADDR : addr_cnt;
    assign w_initLost   = (r_state != IDLE) && (r_state != DONE) && (r_state != ABORT)
                          && (!cmd_init || !addr_init);
    assign w_timedOut   = (r_toCnt >= L_TIMEOUT);

    // Decide, for the current WAIT state, which unit is being waited on and
    // which step follows; the next unit must also be idle before its strobe
    always_comb begin
        w_ownBusy = 1'b0;
        w_goAddr  = 1'b0;
        w_goCmd1  = 1'b0;
        w_nextIdx = 3'd0;
        case (r_state)
            C0_WAIT: begin
                w_ownBusy = cmd_busy;
                w_goAddr  = (r_addrCnt != 3'd0);
                w_goCmd1  = r_cmd1En;
                w_nextIdx = 3'd0;
            end
            A_WAIT: begin
                w_ownBusy = addr_busy;
                w_nextIdx = r_idx + 3'd1;
                w_goAddr  = ((r_idx + 3'd1) < r_addrCnt);
                w_goCmd1  = r_cmd1En;
            end
            C1_WAIT: begin
                w_ownBusy = cmd_busy;
            end
            default: ;
        endcase
        w_tgtBusy   = w_goAddr ? addr_busy : (w_goCmd1 ? cmd_busy : 1'b0);
        w_stepClear = ~w_ownBusy & ~w_tgtBusy;
    end

    // Main sequencer: strobes, data and pulses are all registered here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cmd0     <= 8'h00;
            r_addr     <= 40'h0;
            r_addrCnt  <= 3'd0;
            r_cmd1En   <= 1'b0;
            r_cmd1     <= 8'h00;
            r_idx      <= 3'd0;
            r_toCnt    <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cmdAct   <= 1'b0;
            r_addrAct  <= 1'b0;
            r_cmdData  <= 16'h0000;
            r_addrData <= 16'h0000;
        end else begin
            r_cmdAct  <= 1'b0;
            r_addrAct <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            if (w_initLost) begin
                r_state    <= ABORT;
                r_error    <= 1'b1;
                r_cmdData  <= 16'h0000;
                r_addrData <= 16'h0000;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_cmd0    <= cmd0;
                            r_addr    <= addr;
                            r_addrCnt <= w_cntClamped;
                            r_cmd1En  <= cmd1_en;
                            r_cmd1    <= cmd1;
                            r_idx     <= 3'd0;
                            r_toCnt   <= '0;
                            r_cmdAct  <= 1'b1;
                            r_cmdData <= {8'h00, cmd0};
                            r_state   <= C0_REQ;
                        end
                    end
                    C0_REQ: begin
                        r_toCnt <= '0;
                        r_state <= C0_ARM;
                    end
                    A_REQ: begin
                        r_toCnt <= '0;
                        r_state <= A_ARM;
                    end
                    C1_REQ: begin
                        r_toCnt <= '0;
                        r_state <= C1_ARM;
                    end
                    C0_ARM: begin
                        r_toCnt <= r_toCnt + 1'b1;
                        r_state <= C0_WAIT;
                    end
                    A_ARM: begin
                        r_toCnt <= r_toCnt + 1'b1;
                        r_state <= A_WAIT;
                    end
                    C1_ARM: begin
                        r_toCnt <= r_toCnt + 1'b1;
                        r_state <= C1_WAIT;
                    end
                    C0_WAIT, A_WAIT, C1_WAIT: begin
                        if (w_stepClear) begin
                            r_toCnt <= '0;
                            if (w_goAddr) begin
                                r_idx      <= w_nextIdx;
                                r_addrAct  <= 1'b1;
                                r_addrData <= {8'h00, addrByte(r_addr, w_nextIdx)};
                                r_state    <= A_REQ;
                            end else if (w_goCmd1) begin
                                r_cmdAct  <= 1'b1;
                                r_cmdData <= {8'h00, r_cmd1};
                                r_state   <= C1_REQ;
                            end else begin
                                r_done     <= 1'b1;
                                r_cmdData  <= 16'h0000;
                                r_addrData <= 16'h0000;
                                r_state    <= DONE;
                            end
                        end else if (w_timedOut) begin
                            r_error    <= 1'b1;
                            r_cmdData  <= 16'h0000;
                            r_addrData <= 16'h0000;
                            r_state    <= ABORT;
                        end else begin
                            r_toCnt <= r_toCnt + 1'b1;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    ABORT:   r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign ready         = w_ready;
    assign done          = r_done;
    assign error         = r_error;
    assign cmd_activate  = r_cmdAct;
    assign cmd_data      = r_cmdData;
    assign addr_activate = r_addrAct;
    assign addr_data     = r_addrData;

endmodule

// File: tb/tb_nand_latch_sequencer.sv
// tb_nand_latch_sequencer
// Directed bench with a behavioural model of both latch units: activate makes
// the unit busy from the next cycle for a fixed latency, and the address unit
// can be made to hang on a chosen activate.
module tb_nand_latch_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  cmd0;
    logic [39:0] addr;
    logic [2:0]  addrCnt;
    logic        cmd1En;
    logic [7:0]  cmd1;
    logic        ready;
    logic        done;
    logic        error;
    logic        cmdActivate;
    logic [15:0] cmdData;
    logic        cmdBusy;
    logic        cmdInit;
    logic        addrActivate;
    logic [15:0] addrData;
    logic        addrBusy;
    logic        addrInit;

    int checkCount = 0;
    int errorCount = 0;

    int cmdLat  = 2;
    int addrLat = 3;
    int hangAt  = 0;
    int cCnt    = 0;
    int aCnt    = 0;
    int aNum    = 0;

    int cycleCnt   = 0;
    int doneCnt    = 0;
    int errCnt     = 0;
    int overlapCnt = 0;
    int errCycle   = 0;
    int addrCycle  = 0;
    logic [15:0] cmdLog[$];
    logic [15:0] addrLog[$];

    nand_latch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cmd0          (cmd0),
        .addr          (addr),
        .addr_cnt      (addrCnt),
        .cmd1_en       (cmd1En),
        .cmd1          (cmd1),
        .ready         (ready),
        .done          (done),
        .error         (error),
        .cmd_activate  (cmdActivate),
        .cmd_data      (cmdData),
        .cmd_busy      (cmdBusy),
        .cmd_init      (cmdInit),
        .addr_activate (addrActivate),
        .addr_data     (addrData),
        .addr_busy     (addrBusy),
        .addr_init     (addrInit)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to time the abort
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Command latch unit model
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cmdBusy <= 1'b0;
            cCnt    <= 0;
        end else if (cmdActivate) begin
            cmdBusy <= 1'b1;
            cCnt    <= cmdLat;
        end else if (cmdBusy) begin
            if (cCnt > 1) cCnt <= cCnt - 1;
            else cmdBusy <= 1'b0;
        end
    end

    // Address latch unit model; stays busy forever on activate number hangAt
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            addrBusy <= 1'b0;
            aCnt     <= 0;
        end else if (addrActivate) begin
            addrBusy <= 1'b1;
            aCnt     <= addrLat;
            aNum     <= aNum + 1;
        end else if (addrBusy) begin
            if (aCnt > 1) aCnt <= aCnt - 1;
            else if (!(hangAt != 0 && aNum == hangAt)) addrBusy <= 1'b0;
        end
    end

    // Monitor on the falling edge: logs strobes, pulses and busy overlaps
    always @(negedge clk) begin
        if (cmdActivate) cmdLog.push_back(cmdData);
        if (addrActivate) begin
            addrLog.push_back(addrData);
            addrCycle <= cycleCnt;
        end
        if (done) doneCnt <= doneCnt + 1;
        if (error) begin
            errCnt   <= errCnt + 1;
            errCycle <= cycleCnt;
        end
        if ((cmdActivate && cmdBusy) || (addrActivate && addrBusy) || (cmdActivate && addrActivate))
            overlapCnt <= overlapCnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] c0, input logic [39:0] a, input logic [2:0] cnt,
                                 input logic c1e, input logic [7:0] c1);
        @(posedge clk); #1;
        cmd0    = c0;
        addr    = a;
        addrCnt = cnt;
        cmd1En  = c1e;
        cmd1    = c1;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic waitResult(input string tag, input int limit);
        int base;
        base = doneCnt + errCnt;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            if (doneCnt + errCnt > base) break;
        end
        #1;
        checkOutput(tag, 64'(doneCnt + errCnt > base), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int cB, aB, dB, eB;
        reset    = 1'b1;
        start    = 1'b0;
        cmd0     = 8'h00;
        addr     = 40'h0;
        addrCnt  = 3'd0;
        cmd1En   = 1'b0;
        cmd1     = 8'h00;
        cmdInit  = 1'b1;
        addrInit = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;

        // 1: reset state, then single command
        checkOutput("rstReady", 64'(ready), 64'd1);
        checkOutput("rstOuts", {cmdData, addrData, done, error, cmdActivate, addrActivate}, 64'd0);
        cB = cmdLog.size(); aB = addrLog.size(); dB = doneCnt; eB = errCnt;
        applyStimulus(8'hFF, 40'h0, 3'd0, 1'b0, 8'h00);
        waitResult("t1Finish", 50);
        checkOutput("t1CmdActs", 64'(cmdLog.size() - cB), 64'd1);
        checkOutput("t1CmdData", 64'(cmdLog[cB]), 64'h00FF);
        checkOutput("t1AddrActs", 64'(addrLog.size() - aB), 64'd0);
        checkOutput("t1Done", 64'(doneCnt - dB), 64'd1);
        checkOutput("t1Err", 64'(errCnt - eB), 64'd0);

        // 2: full read sequence
        cB = cmdLog.size(); aB = addrLog.size(); dB = doneCnt;
        applyStimulus(8'h00, 40'h0504030201, 3'd5, 1'b1, 8'h30);
        waitResult("t2Finish", 200);
        checkOutput("t2AddrActs", 64'(addrLog.size() - aB), 64'd5);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("t2AddrByte%0d", i), 64'(addrLog[aB + i]), 64'(i + 1));
        checkOutput("t2CmdActs", 64'(cmdLog.size() - cB), 64'd2);
        checkOutput("t2Cmd0", 64'(cmdLog[cB]), 64'h0000);
        checkOutput("t2Cmd1", 64'(cmdLog[cB + 1]), 64'h0030);
        checkOutput("t2Done", 64'(doneCnt - dB), 64'd1);

        // 3: address unit hangs on the 2nd byte -> timeout abort
        aB = addrLog.size(); dB = doneCnt; eB = errCnt;
        hangAt = aNum + 2;
        applyStimulus(8'h00, 40'h0504030201, 3'd5, 1'b1, 8'h30);
        waitResult("t3Finish", 1200);
        checkOutput("t3Err", 64'(errCnt - eB), 64'd1);
        checkOutput("t3NoDone", 64'(doneCnt - dB), 64'd0);
        checkOutput("t3AddrActs", 64'(addrLog.size() - aB), 64'd2);
        checkOutput("t3Latency", 64'(errCycle - addrCycle), 64'd1025);
        checkOutput("t3DataZero", {cmdData, addrData}, 64'd0);
        hangAt = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t3ReadyAgain", 64'(ready), 64'd1);

        // 4: start ignored while active, and while cmd_init is low
        cB = cmdLog.size(); dB = doneCnt;
        cmdLat = 6;
        applyStimulus(8'h70, 40'h0, 3'd0, 1'b0, 8'h00);
        applyStimulus(8'h90, 40'h0, 3'd0, 1'b0, 8'h00);
        waitResult("t4Finish", 50);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("t4CmdActs", 64'(cmdLog.size() - cB), 64'd1);
        checkOutput("t4CmdData", 64'(cmdLog[cB]), 64'h0070);
        checkOutput("t4Done", 64'(doneCnt - dB), 64'd1);
        cmdLat = 2;
        cmdInit = 1'b0;
        #1;
        checkOutput("t4NotReady", 64'(ready), 64'd0);
        cB = cmdLog.size(); aB = addrLog.size();
        applyStimulus(8'h55, 40'h0, 3'd1, 1'b0, 8'h00);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t4NoActs", 64'((cmdLog.size() - cB) + (addrLog.size() - aB)), 64'd0);
        cmdInit = 1'b1;

        // 5: reset during A_WAIT
        aB = addrLog.size();
        applyStimulus(8'h00, 40'h0000030201, 3'd3, 1'b0, 8'h00);
        for (int i = 0; i < 50 && addrLog.size() == aB; i++) @(negedge clk);
        checkOutput("t5AddrSeen", 64'(addrLog.size() > aB), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5RstOuts", {cmdData, addrData, done, error, cmdActivate, addrActivate}, 64'd0);
        dB = doneCnt; eB = errCnt;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t5NoPulses", 64'((doneCnt - dB) + (errCnt - eB)), 64'd0);
        cB = cmdLog.size(); aB = addrLog.size(); dB = doneCnt;
        applyStimulus(8'h12, 40'h000000B2A1, 3'd2, 1'b0, 8'h00);
        waitResult("t5Finish", 100);
        checkOutput("t5CmdData", 64'(cmdLog[cB]), 64'h0012);
        checkOutput("t5AddrActs", 64'(addrLog.size() - aB), 64'd2);
        checkOutput("t5Byte0", 64'(addrLog[aB]), 64'h00A1);
        checkOutput("t5Byte1", 64'(addrLog[aB + 1]), 64'h00B2);
        checkOutput("t5Done", 64'(doneCnt - dB), 64'd1);

        // 6: addr_cnt above the maximum is clamped
        aB = addrLog.size(); dB = doneCnt;
        applyStimulus(8'h00, 40'h0504030201, 3'd7, 1'b0, 8'h00);
        waitResult("t6Finish", 200);
        checkOutput("t6AddrActs", 64'(addrLog.size() - aB), 64'd5);
        checkOutput("t6LastByte", 64'(addrLog[addrLog.size() - 1]), 64'h0005);
        checkOutput("t6Done", 64'(doneCnt - dB), 64'd1);
        checkOutput("overlaps", 64'(overlapCnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
